fib_bcd_ctl: RTL and testbench

FIB_BCD_CTL -- requirements
Module: fib_bcd_ctl

---
 rtl/fib_pkg.sv | 28 ++
 rtl/bin2bcd_dd.sv | 73 +++++++
 rtl/fib_bcd_ctl.sv | 145 ++++++++++++++
 tb/tb_fib_bcd_ctl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constant helpers for the Fibonacci-to-BCD controller.
package fib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    B2B,
    FIB,
    DAB,
    DONE
  } fib_state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned BCD_MAX_DIGIT = 9;

  function automatic int unsigned pow10(input int unsigned d);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  // Out-of-range BCD digits saturate to 9.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > bcd_t'(BCD_MAX_DIGIT)) ? bcd_t'(BCD_MAX_DIGIT) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble binary-to-BCD converter, one shift per cycle.
// The first shift happens on the start edge; o_done pulses after the W-th shift.
module bin2bcd_dd
  import fib_pkg::*;
#(
  parameter int unsigned W      = 20,
  parameter int unsigned DIGITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [W-1:0]            i_bin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [DIGITS-1:0][3:0]  o_bcd
);

  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [W-1:0]           sreg, sreg_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [DIGITS-1:0][3:0] bcd_d;
  bcd_t [DIGITS-1:0]      adj;
  logic [BCD_W+W-1:0]     sh;
  logic                   busy_d, done_d;

  // Upper digits are simply dropped: carries only move upward, so the low digits stay exact.
  always_comb begin
    sreg_d = sreg;
    cnt_d  = cnt;
    bcd_d  = o_bcd;
    busy_d = o_busy;
    done_d = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[i] = (o_bcd[i] >= 4'd5) ? (o_bcd[i] + 4'd3) : o_bcd[i];
    end
    sh = {adj, sreg} << 1;
    if (o_busy) begin
      sreg_d = sh[W-1:0];
      bcd_d  = sh[BCD_W+W-1:W];
      cnt_d  = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (i_start) begin
      sh     = {BCD_W'(0), i_bin} << 1;
      sreg_d = sh[W-1:0];
      bcd_d  = sh[BCD_W+W-1:W];
      cnt_d  = CNT_W'(W - 1);
      busy_d = (W > 1);
      done_d = (W == 1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sreg   <= '0;
      cnt    <= '0;
      o_bcd  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      sreg   <= sreg_d;
      cnt    <= cnt_d;
      o_bcd  <= bcd_d;
      o_busy <= busy_d;
      o_done <= done_d;
    end
  end

endmodule

// File: rtl/fib_bcd_ctl.sv
// Computes fib(n) for a BCD index n and returns the low OUT_DIGITS BCD digits.
// Define FIB_BCD_OVF_EN to saturate to all-9s with o_overflow when fib(n) does not fit.
module fib_bcd_ctl
  import fib_pkg::*;
#(
  parameter int unsigned IN_DIGITS  = 2,
  parameter int unsigned OUT_DIGITS = 4,
  parameter int unsigned FIB_W      = 20
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [IN_DIGITS-1:0][3:0]   i_gen_amt_bcd,
  output logic [OUT_DIGITS-1:0][3:0]  o_final_bcd,
  output logic                        o_ready,
  output logic                        o_done,
  output logic                        o_overflow
);

  localparam int unsigned DIG_W = (IN_DIGITS > 1) ? $clog2(IN_DIGITS) : 1;

  fib_state_t                  state, state_d;
  logic [IN_DIGITS-1:0][3:0]   cap, cap_d;
  logic [DIG_W-1:0]            dig_cnt, dig_cnt_d;
  logic [FIB_W-1:0]            acc, acc_d;
  logic [FIB_W-1:0]            a, a_d, b, b_d;
  logic [OUT_DIGITS-1:0][3:0]  final_d;
  logic                        dd_start_c, dd_busy, dd_done;
  logic [OUT_DIGITS-1:0][3:0]  dd_bcd;

`ifdef FIB_BCD_OVF_EN
  localparam logic [FIB_W:0] OVF_LIMIT = (FIB_W + 1)'(pow10(OUT_DIGITS) - 1);
  logic [FIB_W:0] sum;
  logic           ovf_d;
`endif

  bin2bcd_dd #(
    .W      (FIB_W),
    .DIGITS (OUT_DIGITS)
  ) u_dd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (dd_start_c),
    .i_bin   (a),
    .o_busy  (dd_busy),
    .o_done  (dd_done),
    .o_bcd   (dd_bcd)
  );

  // acc holds the binary index during B2B and doubles as the FIB down-counter.
  always_comb begin
    state_d    = state;
    cap_d      = cap;
    dig_cnt_d  = dig_cnt;
    acc_d      = acc;
    a_d        = a;
    b_d        = b;
    final_d    = o_final_bcd;
    dd_start_c = 1'b0;
`ifdef FIB_BCD_OVF_EN
    ovf_d      = o_overflow;
    sum        = {1'b0, a} + {1'b0, b};
`endif
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_d   = B2B;
          cap_d     = i_gen_amt_bcd;
          dig_cnt_d = DIG_W'(IN_DIGITS - 1);
          acc_d     = '0;
          a_d       = '0;
          b_d       = FIB_W'(1);
`ifdef FIB_BCD_OVF_EN
          ovf_d     = 1'b0;
`endif
        end
      end
      B2B: begin
        acc_d     = (acc << 3) + (acc << 1) + FIB_W'(bcd_clamp(cap[IN_DIGITS-1]));
        cap_d     = cap << 4;
        dig_cnt_d = dig_cnt - DIG_W'(1);
        if (dig_cnt == '0) state_d = FIB;
      end
      FIB: begin
        if (acc != '0) begin
          a_d   = b;
          b_d   = a + b;
          acc_d = acc - FIB_W'(1);
        end
        if (acc <= FIB_W'(1)) state_d = DAB;
`ifdef FIB_BCD_OVF_EN
        // The new b becomes a on a later step, so it must fit while steps remain.
        if ((acc > FIB_W'(1)) && (sum > OVF_LIMIT)) begin
          state_d = DONE;
          ovf_d   = 1'b1;
          for (int unsigned i = 0; i < OUT_DIGITS; i++) final_d[i] = bcd_t'(BCD_MAX_DIGIT);
        end
`endif
      end
      DAB: begin
        dd_start_c = !dd_busy && !dd_done;
        if (dd_done) begin
          state_d = DONE;
          final_d = dd_bcd;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cap         <= '0;
      dig_cnt     <= '0;
      acc         <= '0;
      a           <= '0;
      b           <= '0;
      o_final_bcd <= '0;
      o_done      <= 1'b0;
      o_ready     <= 1'b1;
    end else begin
      state       <= state_d;
      cap         <= cap_d;
      dig_cnt     <= dig_cnt_d;
      acc         <= acc_d;
      a           <= a_d;
      b           <= b_d;
      o_final_bcd <= final_d;
      o_done      <= (state_d == DONE);
      o_ready     <= (state_d == IDLE);
    end
  end

`ifdef FIB_BCD_OVF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_overflow <= 1'b0;
    else       o_overflow <= ovf_d;
  end
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fib_bcd_ctl.sv
// Directed bench for fib_bcd_ctl at default parameters (either FIB_BCD_OVF_EN setting).
module tb_fib_bcd_ctl;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_start;
  logic [1:0][3:0] i_gen_amt_bcd;
  logic [3:0][3:0] o_final_bcd;
  logic            o_ready;
  logic            o_done;
  logic            o_overflow;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] prev_res = 16'h0000;

  typedef struct {
    logic [7:0]  n;
    logic [15:0] exp_res;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  fib_bcd_ctl #(
    .IN_DIGITS  (2),
    .OUT_DIGITS (4),
    .FIB_W      (20)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_gen_amt_bcd (i_gen_amt_bcd),
    .o_final_bcd   (o_final_bcd),
    .o_ready       (o_ready),
    .o_done        (o_done),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: Fibonacci wrapped to 20 bits, low four decimal digits as BCD.
  function automatic logic [15:0] fib_bcd_model(input int n);
    logic [19:0] fa, fb, ft;
    int unsigned v;
    logic [15:0] r;
    fa = '0;
    fb = 20'd1;
    for (int i = 0; i < n; i++) begin
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end
    v = 32'(fa) % 10000;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic start_n(input logic [7:0] n);
    @(negedge i_clk);
    i_gen_amt_bcd = n;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [7:0] n, input logic [15:0] exp_res,
                         input logic exp_ovf, input int exp_lat);
    int lat;
    start_n(n);
    lat = 0;
    while (o_done !== 1'b1 && lat < 300) begin
      @(posedge i_clk);
      #1;
      lat++;
      if (lat == 2) begin
        check({tag, " ready_busy"}, 32'(o_ready), 32'd0);
        check({tag, " hold"}, 32'(o_final_bcd), 32'(prev_res));
        check({tag, " ovf_clear"}, 32'(o_overflow), 32'd0);
      end
    end
    check({tag, " done_seen"}, 32'(o_done), 32'd1);
    check({tag, " result"}, 32'(o_final_bcd), 32'(exp_res));
    check({tag, " overflow"}, 32'(o_overflow), 32'(exp_ovf));
    if (exp_lat >= 0) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    @(posedge i_clk);
    #1;
    check({tag, " done_pulse"}, 32'(o_done), 32'd0);
    check({tag, " ready_after"}, 32'(o_ready), 32'd1);
    prev_res = exp_res;
  endtask

  initial begin
    int done_cnt;
    int first_done;

    vecs[0]  = '{8'h10, 16'h0055, 1'b0, 33};
    vecs[1]  = '{8'h20, 16'h6765, 1'b0, 43};
    vecs[2]  = '{8'h00, 16'h0000, 1'b0, 24};
    vecs[3]  = '{8'h01, 16'h0001, 1'b0, 24};
    vecs[4]  = '{8'h02, 16'h0001, 1'b0, 25};
    vecs[5]  = '{8'h05, 16'h0005, 1'b0, 28};
    vecs[6]  = '{8'h19, 16'h4181, 1'b0, 42};
    vecs[7]  = '{8'h0A, 16'h0034, 1'b0, 32};
`ifdef FIB_BCD_OVF_EN
    vecs[8]  = '{8'h21, 16'h9999, 1'b1, -1};
    vecs[9]  = '{8'h30, 16'h9999, 1'b1, -1};
    vecs[10] = '{8'h25, 16'h9999, 1'b1, -1};
    vecs[11] = '{8'hA0, 16'h9999, 1'b1, -1};
`else
    vecs[8]  = '{8'h21, 16'h0946, 1'b0, 44};
    vecs[9]  = '{8'h30, 16'h2040, 1'b0, 53};
    vecs[10] = '{8'h25, 16'h5025, 1'b0, 48};
    vecs[11] = '{8'hA0, fib_bcd_model(90), 1'b0, 113};
`endif

    i_rst = 1'b1;
    i_start = 1'b0;
    i_gen_amt_bcd = '0;
    #12;
    check("reset result", 32'(o_final_bcd), 32'd0);
    check("reset done", 32'(o_done), 32'd0);
    check("reset overflow", 32'(o_overflow), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("reset ready", 32'(o_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d_n%0h", i, vecs[i].n), vecs[i].n, vecs[i].exp_res,
              vecs[i].exp_ovf, vecs[i].exp_lat);
    end

    // Second start mid-FIB must be ignored.
    start_n(8'h10);
    done_cnt = 0;
    first_done = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge i_clk);
      #1;
      if (o_done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (c == 4) begin
        i_gen_amt_bcd = 8'h99;
        i_start = 1'b1;
      end
      if (c == 5) i_start = 1'b0;
    end
    check("restart done_count", 32'(done_cnt), 32'd1);
    check("restart latency", 32'(first_done), 32'd33);
    check("restart result", 32'(o_final_bcd), 32'h0055);
    check("restart overflow", 32'(o_overflow), 32'd0);
    prev_res = 16'h0055;

    // Reset asserted during DAB abandons the computation.
    start_n(8'h10);
    for (int c = 1; c <= 20; c++) begin
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b1;
    #1;
    check("midrst result", 32'(o_final_bcd), 32'd0);
    check("midrst done", 32'(o_done), 32'd0);
    check("midrst overflow", 32'(o_overflow), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("midrst ready", 32'(o_ready), 32'd1);
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge i_clk);
      #1;
      if (o_done === 1'b1) done_cnt++;
    end
    check("midrst no_done", 32'(done_cnt), 32'd0);
    prev_res = 16'h0000;
    run_vec("after_rst_n5", 8'h05, 16'h0005, 1'b0, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
